// File: rtl/ctr_pkg.sv
// Shared constants for the dynamic count-to counter family: terminal modes
// and the one-bit run/done state encoding.
package ctr_pkg;

   localparam logic [1:0] MODE_FREE    = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;
   localparam logic [1:0] MODE_ONESHOT = 2'b10;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } ctr_state_t;

   // Mode 2'b11 is reserved and behaves as free-run.
   function automatic logic [1:0] eff_mode(input logic [1:0] m);
      return (m == 2'b11) ? MODE_FREE : m;
   endfunction

endpackage

// File: rtl/ctr_prescaler.sv
// Clock-enable prescaler: emits one tick every prescale+1 enabled cycles.
// No valid/ready handshake here; tick is a single-cycle qualifier.
module ctr_prescaler #(
   parameter int PRE_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             cen,
   input  logic [PRE_W-1:0] prescale,
   output logic             tick
);

   logic [PRE_W-1:0] pre_cnt;

   // Using >= keeps the prescaler from running away if prescale is lowered
   // below the current phase.
   assign tick = cen && (pre_cnt >= prescale);

   // Phase counter: cleared by load, wraps on tick, frozen while disabled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_cnt <= '0;
      end else if (clr) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else if (cen) begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/updn_ctr_dcnto_ext.sv
// Up/down counter with a dynamic terminal value, prescaled advance, three
// terminal modes and registered terminal pulse / sticky flag outputs.
// The one-bit FSM state is visible directly on `done`.
module updn_ctr_dcnto_ext
   import ctr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int PRE_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             cen,
   input  logic             up_dn,
   input  logic [1:0]       mode,
   input  logic [PRE_W-1:0] prescale,
   input  logic [WIDTH-1:0] data,
   input  logic [WIDTH-1:0] count_to,
   input  logic             tc_clr,
   output logic [WIDTH-1:0] count,
   output logic             tercnt,
   output logic             tc_pulse,
   output logic             tc_flag,
   output logic             done
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   ctr_state_t       state, state_nx;
   logic [WIDTH-1:0] count_nx;
   logic             tick;
   logic             do_load;
   logic             advance;
   logic             hit;
   logic [1:0]       m;

   assign do_load = ~load;
   assign m       = eff_mode(mode);
   assign tercnt  = (count == count_to);
   assign advance = tick && !do_load && (state == ST_RUN);
   assign done    = (state == ST_DONE);

   ctr_prescaler #(.PRE_W(PRE_W)) u_pre (
      .clk      (clk),
      .reset    (reset),
      .clr      (do_load),
      .cen      (cen),
      .prescale (prescale),
      .tick     (tick)
   );

   // Next count / next state: load first, then advance by terminal mode.
   always_comb begin
      count_nx = count;
      state_nx = state;
      if (do_load) begin
         count_nx = data;
         state_nx = ST_RUN;
      end else if (advance) begin
         if (tercnt && (m == MODE_RELOAD)) begin
            count_nx = data;
         end else if (tercnt && (m == MODE_ONESHOT)) begin
            count_nx = count;
            state_nx = ST_DONE;
         end else if (up_dn) begin
            count_nx = count + ONE;
         end else begin
            count_nx = count - ONE;
         end
      end
   end

   // A terminal hit is an advance whose resulting count equals count_to;
   // loads never count as hits.
   assign hit = advance && (count_nx == count_to);

   // Count register and FSM state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         state <= ST_RUN;
      end else begin
         count <= count_nx;
         state <= state_nx;
      end
   end

   // Terminal pulse and sticky flag; a set beats a simultaneous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tc_pulse <= 1'b0;
         tc_flag  <= 1'b0;
      end else begin
         tc_pulse <= hit;
         if (hit) begin
            tc_flag <= 1'b1;
         end else if (tc_clr) begin
            tc_flag <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_updn_ctr_dcnto_ext.sv
// Directed bench for updn_ctr_dcnto_ext (WIDTH=8, PRE_W=4).
module tb_updn_ctr_dcnto_ext;

   logic       clk = 1'b0;
   logic       reset;
   logic       load;
   logic       cen;
   logic       up_dn;
   logic [1:0] mode;
   logic [3:0] prescale;
   logic [7:0] data;
   logic [7:0] count_to;
   logic       tc_clr;
   logic [7:0] count;
   logic       tercnt;
   logic       tc_pulse;
   logic       tc_flag;
   logic       done;

   int n_tests = 0;
   int n_fail  = 0;

   // Clock
   always #5 clk = ~clk;

   updn_ctr_dcnto_ext #(.WIDTH(8), .PRE_W(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .cen      (cen),
      .up_dn    (up_dn),
      .mode     (mode),
      .prescale (prescale),
      .data     (data),
      .count_to (count_to),
      .tc_clr   (tc_clr),
      .count    (count),
      .tercnt   (tercnt),
      .tc_pulse (tc_pulse),
      .tc_flag  (tc_flag),
      .done     (done)
   );

   // Advance one clock edge; outputs are sampled 1 ns after it.
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Check count plus pulse/flag in one call.
   task automatic chk3(input string tag, input logic [7:0] c, input logic p, input logic f);
      chk({tag, ".count"}, {24'd0, count}, {24'd0, c});
      chk({tag, ".pulse"}, {31'd0, tc_pulse}, {31'd0, p});
      chk({tag, ".flag"}, {31'd0, tc_flag}, {31'd0, f});
   endtask

   initial begin
      reset = 1'b1; load = 1'b1; cen = 1'b0; up_dn = 1'b1; mode = 2'b00;
      prescale = 4'd0; data = 8'h00; count_to = 8'h00; tc_clr = 1'b0;
      step(2);
      // Reset state
      chk3("rst", 8'h00, 1'b0, 1'b0);
      chk("rst.done", {31'd0, done}, 32'd0);
      chk("rst.tercnt", {31'd0, tercnt}, 32'd1);

      // Load during run
      reset = 1'b0; count_to = 8'h10;
      step();
      chk("rst.tercnt_dyn", {31'd0, tercnt}, 32'd0);
      load = 1'b0; data = 8'h05;
      step();
      chk3("load5", 8'h05, 1'b0, 1'b0);
      load = 1'b1;

      // Free-run up with wrap, count_to = 01
      load = 1'b0; data = 8'hFD; count_to = 8'h01; cen = 1'b1;
      step();
      chk3("fr.ld", 8'hFD, 1'b0, 1'b0);
      load = 1'b1;
      step(); chk3("fr.FE", 8'hFE, 1'b0, 1'b0);
      step(); chk3("fr.FF", 8'hFF, 1'b0, 1'b0);
      step(); chk3("fr.00", 8'h00, 1'b0, 1'b0);
      step(); chk3("fr.01", 8'h01, 1'b1, 1'b1);
      chk("fr.tercnt01", {31'd0, tercnt}, 32'd1);
      step(); chk3("fr.02", 8'h02, 1'b0, 1'b1);
      chk("fr.tercnt02", {31'd0, tercnt}, 32'd0);
      // tercnt follows count_to with zero latency, no pulse
      count_to = 8'h02; #1;
      chk("fr.dyn_tercnt", {31'd0, tercnt}, 32'd1);
      count_to = 8'h01;
      tc_clr = 1'b1;
      step(); chk3("fr.clr", 8'h03, 1'b0, 1'b0);
      tc_clr = 1'b0;

      // Auto-reload down
      load = 1'b0; data = 8'h04; count_to = 8'h01; up_dn = 1'b0; mode = 2'b01;
      step(); chk3("ar.ld", 8'h04, 1'b0, 1'b0);
      load = 1'b1;
      step(); chk3("ar.03", 8'h03, 1'b0, 1'b0);
      step(); chk3("ar.02", 8'h02, 1'b0, 1'b0);
      step(); chk3("ar.01", 8'h01, 1'b1, 1'b1);
      step(); chk3("ar.rl04", 8'h04, 1'b0, 1'b1);
      step(); chk3("ar.03b", 8'h03, 1'b0, 1'b1);

      // Flag set/clear race
      tc_clr = 1'b1;
      step(); chk3("race.clr", 8'h02, 1'b0, 1'b0);
      step(); chk3("race.setwins", 8'h01, 1'b1, 1'b1);
      step(); chk3("race.clr2", 8'h04, 1'b0, 1'b0);
      tc_clr = 1'b0;

      // Prescale 2 + one-shot up to 3
      cen = 1'b0; load = 1'b0; data = 8'h00; count_to = 8'h03; mode = 2'b10;
      up_dn = 1'b1; prescale = 4'd2;
      step(); chk3("os.ld", 8'h00, 1'b0, 1'b0);
      load = 1'b1; cen = 1'b1;
      step(2); chk3("os.e2", 8'h00, 1'b0, 1'b0);
      step();  chk3("os.e3", 8'h01, 1'b0, 1'b0);
      // cen low freezes the prescaler phase
      cen = 1'b0;
      step(4); chk3("os.hold", 8'h01, 1'b0, 1'b0);
      cen = 1'b1;
      step(2); chk3("os.e5", 8'h01, 1'b0, 1'b0);
      step();  chk3("os.e6", 8'h02, 1'b0, 1'b0);
      step(3); chk3("os.e9", 8'h03, 1'b1, 1'b1);
      chk("os.e9.done", {31'd0, done}, 32'd0);
      step(2);
      chk("os.e11.done", {31'd0, done}, 32'd0);
      step();
      chk("os.e12.done", {31'd0, done}, 32'd1);
      chk("os.e12.count", {24'd0, count}, 32'h03);
      step(6);
      chk("os.frozen", {24'd0, count}, 32'h03);
      chk("os.frozen.done", {31'd0, done}, 32'd1);
      mode = 2'b00;
      step(3);
      chk("os.modechg.done", {31'd0, done}, 32'd1);
      chk("os.modechg.count", {24'd0, count}, 32'h03);
      load = 1'b0; data = 8'h30; prescale = 4'd0; count_to = 8'h37;
      step();
      chk("os.exit.done", {31'd0, done}, 32'd0);
      chk3("os.exit", 8'h30, 1'b0, 1'b1);
      load = 1'b1;

      // Async reset mid-run at 0x37
      step(7);
      chk3("ar37", 8'h37, 1'b1, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      chk3("async", 8'h00, 1'b0, 1'b0);
      chk("async.done", {31'd0, done}, 32'd0);
      step();
      reset = 1'b0;
      step();
      chk("post_rst.count", {24'd0, count}, 32'h01);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
